fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the fetch sequencer   |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] align_target(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_sequencer : single-entry instruction fetch sequencer       |
// | Optional macro FETCH_MISALIGN_CHK_EN adds MisalignErr output.    |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        Clk,
  input  logic        R,
  input  logic [31:0] PC,
  output logic [31:0] PCnot,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [31:0] Inst,
  output logic [31:0] InstPC
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        MisalignErr
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_saved_target;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_pc;
  logic         r_imem_req;
  logic         r_inst_valid;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_plus;
  logic [31:0]  w_pcnot;

  assign w_target  = align_target(RedirectTarget);
  assign w_pc_plus = PC + 32'(INSTR_BYTES);

  // PC register holds still by default so an outstanding request keeps its address
  always_comb begin
    w_pcnot = PC;
    case (r_state)
      IDLE: w_pcnot = RESET_VECTOR;
      REQ:  if (ImemAck) w_pcnot = Redirect ? w_target : w_pc_plus;
      KILL: if (ImemAck) w_pcnot = Redirect ? w_target : r_saved_target;
      HOLD: if (Redirect) w_pcnot = w_target;
      default: w_pcnot = RESET_VECTOR;
    endcase
  end

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      r_state        <= IDLE;
      r_saved_target <= 32'h0;
      r_inst         <= 32'h0;
      r_inst_pc      <= 32'h0;
      r_imem_req     <= 1'b0;
      r_inst_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= REQ;
          r_imem_req <= 1'b1;
        end
        REQ: begin
          if (ImemAck && !Redirect) begin
            r_inst       <= ImemRdata;
            r_inst_pc    <= PC;
            r_state      <= HOLD;
            r_imem_req   <= 1'b0;
            r_inst_valid <= 1'b1;
          end else if (!ImemAck && Redirect) begin
            r_saved_target <= w_target;
            r_state        <= KILL;
          end
        end
        KILL: begin
          if (Redirect) r_saved_target <= w_target;
          if (ImemAck) r_state <= REQ;
        end
        HOLD: begin
          if (Redirect || InstReady) begin
            r_state      <= REQ;
            r_imem_req   <= 1'b1;
            r_inst_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_imem_req   <= 1'b0;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= Redirect && (r_state != IDLE) && (RedirectTarget[1:0] != 2'b00);
    end
  end

  assign MisalignErr = r_misalign;
`endif

  assign PCnot     = w_pcnot;
  assign ImemReq   = r_imem_req;
  assign ImemAddr  = PC;
  assign InstValid = r_inst_valid;
  assign Inst      = r_inst;
  assign InstPC    = r_inst_pc;

endmodule
`default_nettype wire
